// File: rtl/dvi_pkg.sv
// Shared DVI/TMDS definitions: symbol widths, control tokens and receive-side types.
package dvi_pkg;

  localparam int TMDS_W  = 10;
  localparam int COLOR_W = 8;

  // Control tokens written MSB first; bit 0 is the first bit on the wire.
  localparam logic [TMDS_W-1:0] TMDS_CTRL_00 = 10'b1101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_01 = 10'b0010101011;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_10 = 10'b0101010100;
  localparam logic [TMDS_W-1:0] TMDS_CTRL_11 = 10'b1010101011;

  typedef enum logic {
    RX_SEARCH,
    RX_LOCKED
  } tmds_rx_state_t;

  typedef struct packed {
    logic               is_ctrl;
    logic               c1;
    logic               c0;
    logic [COLOR_W-1:0] data;
  } tmds_sym_t;

endpackage

// File: rtl/tmds_decoder.sv
// Combinational TMDS symbol decoder: 10-bit symbol to control flag, C1/C0 and data byte.
module tmds_decoder
  import dvi_pkg::*;
(
  input  logic [TMDS_W-1:0] sym_i,
  output tmds_sym_t         dec_o
);

  logic [COLOR_W-1:0] t;
  logic [COLOR_W-1:0] data;

  // Bit 9 flags a DC-balancing inversion, bit 8 selects XOR or XNOR chaining.
  assign t       = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
  assign data[0] = t[0];

  genvar gi;
  generate
    for (gi = 1; gi < COLOR_W; gi++) begin : g_bit
      assign data[gi] = sym_i[8] ? (t[gi] ^ t[gi-1]) : ~(t[gi] ^ t[gi-1]);
    end
  endgenerate

  always_comb begin
    dec_o.is_ctrl = 1'b1;
    dec_o.c1      = 1'b0;
    dec_o.c0      = 1'b0;
    dec_o.data    = data;
    case (sym_i)
      TMDS_CTRL_00: {dec_o.c1, dec_o.c0} = 2'b00;
      TMDS_CTRL_01: {dec_o.c1, dec_o.c0} = 2'b01;
      TMDS_CTRL_10: {dec_o.c1, dec_o.c0} = 2'b10;
      TMDS_CTRL_11: {dec_o.c1, dec_o.c0} = 2'b11;
      default:      dec_o.is_ctrl = 1'b0;
    endcase
  end

endmodule

// File: rtl/tmds_rx_channel.sv
// One TMDS receive channel: finds the word boundary from control-token runs,
// then decodes aligned symbols into pixel data, C0/C1 and DE.
module tmds_rx_channel
  import dvi_pkg::*;
#(
  parameter int LOCK_TOKENS  = 16,
  parameter int SEARCH_WIN   = 1024,
  parameter int LOSS_TIMEOUT = 2048
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [TMDS_W-1:0]  raw_i,
  output logic [COLOR_W-1:0] data_o,
  output logic               c0_o,
  output logic               c1_o,
  output logic               de_o,
  output logic               locked_o,
  output logic [3:0]         offset_o
);

  localparam int RUN_W  = $clog2(LOCK_TOKENS) + 1;
  localparam int WIN_W  = $clog2(SEARCH_WIN) + 1;
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT) + 1;

  localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(LOCK_TOKENS - 1);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(SEARCH_WIN - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_TIMEOUT - 1);

  tmds_rx_state_t      state_reg;
  logic [TMDS_W-1:0]   raw_prev_reg;
  logic [3:0]          offset_reg;
  logic [RUN_W-1:0]    run_cnt_reg;
  logic [WIN_W-1:0]    win_cnt_reg;
  logic [LOSS_W-1:0]   loss_cnt_reg;
  logic [COLOR_W-1:0]  data_reg;
  logic                c0_reg;
  logic                c1_reg;
  logic                de_reg;
  logic                locked_reg;

  // Offsets 0..9 only ever reach window bit 18, so raw_i[9] enters via raw_prev.
  logic [2*TMDS_W-2:0] window;
  logic [TMDS_W-1:0]   cand [TMDS_W];
  logic [TMDS_W-1:0]   sym;
  tmds_sym_t           dec;

  assign window = {raw_i[TMDS_W-2:0], raw_prev_reg};

  genvar gi;
  generate
    for (gi = 0; gi < TMDS_W; gi++) begin : g_cand
      assign cand[gi] = window[gi+TMDS_W-1:gi];
    end
  endgenerate

  always_comb begin
    sym = cand[0];
    for (int k = 1; k < TMDS_W; k++) begin
      if (offset_reg == 4'(k)) begin
        sym = cand[k];
      end
    end
  end

  tmds_decoder u_decoder (
    .sym_i (sym),
    .dec_o (dec)
  );

  always_ff @(posedge clk_i) begin
    raw_prev_reg <= raw_i;
    if (rst_i) begin
      state_reg    <= RX_SEARCH;
      offset_reg   <= '0;
      run_cnt_reg  <= '0;
      win_cnt_reg  <= '0;
      loss_cnt_reg <= '0;
      data_reg     <= '0;
      c0_reg       <= 1'b0;
      c1_reg       <= 1'b0;
      de_reg       <= 1'b0;
      locked_reg   <= 1'b0;
    end else begin
      case (state_reg)
        RX_SEARCH: begin
          data_reg <= '0;
          c0_reg   <= 1'b0;
          c1_reg   <= 1'b0;
          de_reg   <= 1'b0;
          // A completed token run beats a window expiry in the same cycle.
          if (dec.is_ctrl && run_cnt_reg == RUN_LAST) begin
            state_reg    <= RX_LOCKED;
            locked_reg   <= 1'b1;
            run_cnt_reg  <= '0;
            win_cnt_reg  <= '0;
            loss_cnt_reg <= '0;
          end else if (win_cnt_reg == WIN_LAST) begin
            offset_reg  <= (offset_reg == 4'd9) ? 4'd0 : offset_reg + 4'd1;
            run_cnt_reg <= '0;
            win_cnt_reg <= '0;
          end else begin
            run_cnt_reg <= dec.is_ctrl ? run_cnt_reg + 1'b1 : '0;
            win_cnt_reg <= win_cnt_reg + 1'b1;
          end
        end
        RX_LOCKED: begin
          if (dec.is_ctrl) begin
            de_reg       <= 1'b0;
            c1_reg       <= dec.c1;
            c0_reg       <= dec.c0;
            loss_cnt_reg <= '0;
          end else if (loss_cnt_reg == LOSS_LAST) begin
            // Drop lock but keep the offset so the search restarts where we were.
            state_reg    <= RX_SEARCH;
            locked_reg   <= 1'b0;
            de_reg       <= 1'b0;
            data_reg     <= '0;
            c0_reg       <= 1'b0;
            c1_reg       <= 1'b0;
            loss_cnt_reg <= '0;
            run_cnt_reg  <= '0;
            win_cnt_reg  <= '0;
          end else begin
            de_reg       <= 1'b1;
            data_reg     <= dec.data;
            loss_cnt_reg <= loss_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end

  assign data_o   = data_reg;
  assign c0_o     = c0_reg;
  assign c1_o     = c1_reg;
  assign de_o     = de_reg;
  assign locked_o = locked_reg;
  assign offset_o = offset_reg;

endmodule

// File: doc/tmds_rx_channel.md
Name: tmds_rx_channel

Overview:
- Receive-side counterpart of the TMDS encoder path: one TMDS channel at pixel rate.
- Input is a raw, unaligned 10-bit word per pixel clock from an upstream deserializer.
- The block finds the symbol boundary (word alignment) using control-token runs during blanking, then decodes the aligned symbols to 8-bit data, C0/C1 and DE.
- Three instances plus a sync recovery stage form a DVI receiver.

Parameters:
- LOCK_TOKENS, 16: consecutive control tokens at one offset required to declare lock.
- SEARCH_WIN, 1024: cycles spent at each candidate offset before slipping to the next. Must be at least one line period.
- LOSS_TIMEOUT, 2048: cycles without any control token while locked before lock is dropped.

Ports:
- clk_i, input, 1: pixel clock.
- rst_i, input, 1: synchronous, active-high reset.
- raw_i, input, 10: unaligned deserialized word, bit 0 received first.
- data_o, output, COLOR_W (8): decoded pixel byte.
- c0_o, output, 1: decoded control bit C0.
- c1_o, output, 1: decoded control bit C1.
- de_o, output, 1: data enable; 1 when the current symbol is a data symbol.
- locked_o, output, 1: alignment locked.
- offset_o, output, 4: current bit offset, 0..9.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high.
  - On reset: all outputs 0, offset 0, state SEARCH, all counters 0.
  - Reset asserted mid-lock takes effect at the next edge.
- Window: raw_prev registers raw_i every cycle. window = {raw_i, raw_prev} (20 bits). Aligned symbol sym = window[offset+9 : offset].
- Control tokens, sym[9:0]:
  - 1101010100 gives C1C0 = 00.
  - 0010101011 gives C1C0 = 01.
  - 0101010100 gives C1C0 = 10.
  - 1010101011 gives C1C0 = 11.
  - is_ctrl is 1 when sym matches any of the four.
- Data decode (combinational):
  - t = sym[9] ? ~sym[7:0] : sym[7:0].
  - d[0] = t[0].
  - For i = 1..7: d[i] = sym[8] ? t[i]^t[i-1] : ~(t[i]^t[i-1]).
- State SEARCH:
  - run_cnt increments on is_ctrl and clears on any non-token symbol.
  - win_cnt increments every cycle.
  - When run_cnt reaches LOCK_TOKENS: go to LOCKED, locked_o = 1 from the next cycle, clear both counters, offset unchanged.
  - Otherwise, when win_cnt reaches SEARCH_WIN-1: offset = (offset == 9) ? 0 : offset+1, and clear both counters.
  - If both conditions occur in the same cycle, lock wins and no slip happens.
  - Outputs in SEARCH: de_o = 0, data_o = 0, c0_o = c1_o = 0.
- State LOCKED:
  - Outputs are registered with 1-cycle latency: the symbol completed in cycle n appears on the outputs in cycle n+1.
  - is_ctrl: de_o = 0, c1_o/c0_o = token value, data_o holds its last value, loss_cnt cleared.
  - Not is_ctrl: de_o = 1, data_o = d, c0/c1 hold, loss_cnt increments.
  - When loss_cnt reaches LOSS_TIMEOUT-1 with no token: go to SEARCH at the current offset.
    - Counters clear; locked_o = 0 and de_o = 0 from the next cycle.
    - The search resumes from the current offset, not from 0.
- Counter widths are $clog2 of their limit plus 1; no counter saturates or wraps past its limit.
- offset_o always reflects the registered offset.

Decomposition:
- dvi_pkg gains:
  - TMDS_CTRL_00/01/10/11 as 10-bit localparams.
  - TMDS_W = 10.
  - typedef enum logic {RX_SEARCH, RX_LOCKED} tmds_rx_state_t.
- Sub-module tmds_decoder is purely combinational. It maps sym[9:0] to {is_ctrl, c1, c0, data[7:0]} and is reused by any future receive path.
- tmds_rx_channel contains the window, offset, counters, FSM and output registers.

Test Plan:
- Reset, then raw_i = 0 for 20 cycles: all outputs 0, offset_o = 0, locked_o = 0.
- Aligned stream: 16 cycles of 1101010100 at offset 0, then encoder output for D = 8'hA5. Expect locked_o = 1 after the 16th token, c1/c0 = 00, then de_o = 1 and data_o = A5 one cycle after the data symbol.
- Stream rotated by 3 bits with SEARCH_WIN = 32: offset_o steps 0,1,2,3 every 32 cycles. Lock at offset 3 with no further slip; decoded data matches the encoder for a 256-value sweep.
- All four control tokens in blanking: c1_o/c0_o = 00, 01, 10, 11 in order, with de_o = 0.
- Locked, then data only for LOSS_TIMEOUT cycles: locked_o drops exactly at the timeout, offset is unchanged, and a token run relocks at the same offset.
- run_cnt reaching 16 on the same cycle win_cnt expires: lock is taken and offset does not increment. rst_i asserted while locked returns all outputs to 0 on the next cycle.
